// File: rtl/fetch_predict_unit_if.sv
// Fetch-side bundle between the PC generator and the core.
// BP_STATS_EN adds the predictor statistics outputs.
interface fetch_predict_unit_if;
  logic        start;
  logic        stall;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        upd_vld;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output start, stall,
    output redirect_vld, redirect_pc,
    output upd_vld, upd_pc,
    output upd_taken, upd_target,
    input  pc, pred_taken, pred_target,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  start, stall,
    input  redirect_vld, redirect_pc,
    input  upd_vld, upd_pc,
    input  upd_taken, upd_target,
    output pc, pred_taken, pred_target,
    output stat_branches, stat_mispredicts
  );
`else
  modport master (
    output start, stall,
    output redirect_vld, redirect_pc,
    output upd_vld, upd_pc,
    output upd_taken, upd_target,
    input  pc, pred_taken, pred_target
  );

  modport slave (
    input  start, stall,
    input  redirect_vld, redirect_pc,
    input  upd_vld, upd_pc,
    input  upd_taken, upd_target,
    output pc, pred_taken, pred_target
  );
`endif
endinterface

// File: rtl/fetch_predict_unit.sv
// Fetch PC generator with direct-mapped BTB and 2-bit counters.
// Define BP_STATS_EN for saturating branch/mispredict counters.
module fetch_predict_unit #(
  parameter int unsigned BTB_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_predict_unit_if.slave  bus
);

  localparam int unsigned IDX = $clog2(BTB_ENTRIES);
  localparam int unsigned TW  = 30 - IDX;

  typedef struct packed {
    logic          vld;
    logic [TW-1:0] tag;
    logic [31:0]   tgt;
    logic [1:0]    ctr;
  } btb_t;

  btb_t           btb_q [BTB_ENTRIES];
  btb_t           wr_d;
  logic           wr_en;

  logic [31:0]    pc_q;
  logic [31:0]    pc_d;

  logic [IDX-1:0] l_idx;
  logic [TW-1:0]  l_tag;
  btb_t           l_ent;
  logic           l_hit;
  logic           p_tk;
  logic [31:0]    p_tgt;

  logic [IDX-1:0] u_idx;
  logic [TW-1:0]  u_tag;
  btb_t           u_ent;
  logic           u_hit;

  logic           unused_lsb;

  assign unused_lsb = ^bus.upd_pc[1:0];

  // Lookup reads the registered array, so a same-edge write is not seen
  assign l_idx = pc_q[IDX+1:2];
  assign l_tag = pc_q[31:IDX+2];
  assign l_ent = btb_q[l_idx];
  assign l_hit = l_ent.vld && (l_ent.tag == l_tag);
  assign p_tk  = l_hit && l_ent.ctr[1];
  assign p_tgt = p_tk ? l_ent.tgt : pc_q + 32'd4;

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = p_tk;
  assign bus.pred_target = p_tgt;

  assign u_idx = bus.upd_pc[IDX+1:2];
  assign u_tag = bus.upd_pc[31:IDX+2];
  assign u_ent = btb_q[u_idx];
  assign u_hit = u_ent.vld && (u_ent.tag == u_tag);

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_vld) begin
      pc_d = bus.redirect_pc;
    end else if (bus.start && !bus.stall) begin
      pc_d = p_tgt;
    end
  end

  always_comb begin
    wr_en = 1'b0;
    wr_d  = u_ent;
    if (bus.upd_vld) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (bus.upd_taken) begin
          wr_d.tgt = bus.upd_target;
          if (u_ent.ctr != 2'b11) begin
            wr_d.ctr = u_ent.ctr + 2'd1;
          end
        end else if (u_ent.ctr != 2'b00) begin
          wr_d.ctr = u_ent.ctr - 2'd1;
        end
      end else if (bus.upd_taken) begin
        // Allocation overwrites whatever alias held the slot
        wr_en    = 1'b1;
        wr_d.vld = 1'b1;
        wr_d.tag = u_tag;
        wr_d.tgt = bus.upd_target;
        wr_d.ctr = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_q[i].vld <= 1'b0;
        btb_q[i].tag <= '0;
        btb_q[i].tgt <= '0;
        btb_q[i].ctr <= 2'b01;
      end
    end else if (wr_en) begin
      btb_q[u_idx] <= wr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_q;
  logic [31:0] br_d;
  logic [31:0] mp_q;
  logic [31:0] mp_d;

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (bus.upd_vld && (br_q != 32'hFFFF_FFFF)) begin
      br_d = br_q + 32'd1;
    end
    if (bus.redirect_vld && (mp_q != 32'hFFFF_FFFF)) begin
      mp_d = mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign bus.stat_branches    = br_q;
  assign bus.stat_mispredicts = mp_q;
`endif

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Self-checking bench for fetch_predict_unit: directed cases
// plus randomized traffic against a table-level reference model.
module tb_fetch_predict_unit;

  logic clk;
  logic rst_n;

  fetch_predict_unit_if bus ();

  fetch_predict_unit #(
    .BTB_ENTRIES(64),
    .RESET_PC   (32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference predictor: plain table of entries keyed by word index
  bit          mv   [64];
  int unsigned mtag [64];
  logic [31:0] mtgt [64];
  int          mctr [64];
  logic [31:0] mpc;
  longint      mbr;
  longint      mmp;

  bit          etk;
  logic [31:0] etg;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void mpred(input logic [31:0] p,
                                output bit tk,
                                output logic [31:0] tg);
    int  i;
    bit  hit;
    i   = int'((p >> 2) % 64);
    hit = mv[i] && (mtag[i] == (p >> 8));
    tk  = hit && (mctr[i] >= 2);
    tg  = tk ? mtgt[i] : p + 32'd4;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < 64; i++) begin
      mv[i]   = 1'b0;
      mtag[i] = 0;
      mtgt[i] = '0;
      mctr[i] = 1;
    end
    mpc = 32'h0;
    mbr = 0;
    mmp = 0;
  endfunction

  function automatic void mupdate();
    bit          tk;
    logic [31:0] tg;
    int          i;
    bit          hit;
    mpred(mpc, tk, tg);
    if (bus.redirect_vld) mpc = bus.redirect_pc;
    else if (bus.start && !bus.stall) mpc = tg;
    if (bus.upd_vld) begin
      i   = int'((bus.upd_pc >> 2) % 64);
      hit = mv[i] && (mtag[i] == (bus.upd_pc >> 8));
      if (hit) begin
        if (bus.upd_taken) begin
          mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
          mtgt[i] = bus.upd_target;
        end else begin
          mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
        end
      end else if (bus.upd_taken) begin
        mv[i]   = 1'b1;
        mtag[i] = bus.upd_pc >> 8;
        mtgt[i] = bus.upd_target;
        mctr[i] = 2;
      end
    end
    if (bus.upd_vld && mbr < 64'hFFFF_FFFF) mbr++;
    if (bus.redirect_vld && mmp < 64'hFFFF_FFFF) mmp++;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else mupdate();
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mpred(mpc, etk, etg);
      chk("pc", bus.pc, mpc);
      chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, etk});
      chk("pred_target", bus.pred_target, etg);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.start        = 1'b0;
    bus.stall        = 1'b0;
    bus.redirect_vld = 1'b0;
    bus.redirect_pc  = '0;
    bus.upd_vld      = 1'b0;
    bus.upd_pc       = '0;
    bus.upd_taken    = 1'b0;
    bus.upd_target   = '0;
  endtask

  task automatic upd(logic [31:0] p, bit tk, logic [31:0] t);
    bus.upd_vld    = 1'b1;
    bus.upd_pc     = p;
    bus.upd_taken  = tk;
    bus.upd_target = t;
    step();
    bus.upd_vld    = 1'b0;
  endtask

  task automatic go(logic [31:0] p);
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = p;
    step();
    bus.redirect_vld = 1'b0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc, 32'h0);
    chk("async_rst_pt", {31'd0, bus.pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] raddr();
    return (32'($urandom_range(0, 15)) << 2) |
           (32'($urandom_range(0, 3)) << 8);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("rst_ptgt", bus.pred_target, 32'h4);

    bus.start = 1'b1;
    step();
    chk("seq_pc1", bus.pc, 32'h4);
    step();
    chk("seq_pc2", bus.pc, 32'h8);
    bus.start = 1'b0;

    upd(32'h10, 1'b1, 32'h40);
    go(32'h10);
    chk("alloc_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("alloc_tgt", bus.pred_target, 32'h40);
    bus.start = 1'b1;
    step();
    chk("alloc_next", bus.pc, 32'h40);
    bus.start = 1'b0;

    upd(32'h10, 1'b0, 32'h0);
    upd(32'h10, 1'b0, 32'h0);
    go(32'h10);
    chk("nt_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("nt_tgt", bus.pred_target, 32'h14);

    for (int k = 0; k < 5; k++) upd(32'h10, 1'b1, 32'h40);
    upd(32'h10, 1'b0, 32'h0);
    chk("sat_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("sat_tgt", bus.pred_target, 32'h40);

    go(32'h110);
    chk("alias_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("alias_tgt", bus.pred_target, 32'h114);
    upd(32'h110, 1'b1, 32'h80);
    go(32'h10);
    chk("evict_pt", {31'd0, bus.pred_taken}, 32'd0);
    go(32'h110);
    chk("new_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("new_tgt", bus.pred_target, 32'h80);

    bus.start = 1'b1;
    upd(32'h110, 1'b0, 32'h0);
    chk("same_cyc_pc", bus.pc, 32'h80);
    bus.start = 1'b0;
    go(32'h110);
    chk("same_cyc_after", {31'd0, bus.pred_taken}, 32'd0);

    go(32'hFFFF_FFFC);
    chk("wrap_tgt", bus.pred_target, 32'h0);

    bus.start = 1'b1;
    bus.stall = 1'b1;
    go(32'h200);
    chk("redir_stall", bus.pc, 32'h200);
    step();
    chk("stall_hold", bus.pc, 32'h200);
    bus.stall = 1'b0;
    step();
    mid_reset();

    for (int c = 0; c < 600; c++) begin
      bus.start        = ($urandom % 8) != 0;
      bus.stall        = ($urandom % 5) == 0;
      bus.redirect_vld = ($urandom % 10) == 0;
      bus.redirect_pc  = raddr();
      bus.upd_vld      = ($urandom % 3) == 0;
      bus.upd_pc       = raddr();
      bus.upd_taken    = $urandom_range(0, 1) == 1;
      bus.upd_target   = raddr();
      if (($urandom % 150) == 0) mid_reset();
      else step();
    end
    idle();
    step();

`ifdef BP_STATS_EN
    chk("stat_br", bus.stat_branches, mbr[31:0]);
    chk("stat_mp", bus.stat_mispredicts, mmp[31:0]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
